// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction fetch unit:
//   - bus widths and the default reset PC
//   - main-control opcode constants used by fetch/decode
//   - fetch FSM state encoding
//   - branch displacement helper (sign-extended word offset)
package instr_fetch_unit_pkg;

   localparam int unsigned PC_W     = 32;
   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned JIDX_W   = 26;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2
   } fetch_state_e;

   // Byte displacement of a branch: sext(imm16) << 2.
   function automatic logic [PC_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
      return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read handshake.
//   req   : fetch request, held until ready (master -> slave)
//   addr  : word-aligned fetch address, stable while req=1 (master -> slave)
//   rdata : instruction word, valid only with ready (slave -> master)
//   ready : read-data-valid strobe (slave -> master)
interface instr_fetch_unit_if;
   import instr_fetch_unit_pkg::*;

   logic               req;
   logic [PC_W-1:0]    addr;
   logic [INSTR_W-1:0] rdata;
   logic               ready;

   modport master (output req, output addr, input rdata, input ready);
   modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC selection at retire (purely combinational).
//   pc_plus4_i  : address of the retiring instruction + 4
//   instr_idx_i : instr[25:0] (jump index; low 16 bits are the branch immediate)
//   branch_i    : control Branch
//   zero_i      : ALU Zero
//   jump_i      : control Jump (wins over branch)
//   next_pc_c_o : selected next PC
module pc_next_calc
   import instr_fetch_unit_pkg::*;
(
   input  logic [PC_W-1:0]   pc_plus4_i,
   input  logic [JIDX_W-1:0] instr_idx_i,
   input  logic              branch_i,
   input  logic              zero_i,
   input  logic              jump_i,
   output logic [PC_W-1:0]   next_pc_c_o
);

   // Priority: jump, then taken branch, else fall through; adds wrap mod 2^32.
   always_comb begin
      next_pc_c_o = pc_plus4_i;
      if (jump_i) begin
         next_pc_c_o = {pc_plus4_i[PC_W-1:PC_W-4], instr_idx_i, 2'b00};
      end else if (branch_i && zero_i) begin
         next_pc_c_o = pc_plus4_i + branch_offset(instr_idx_i[IMM_W-1:0]);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side producer for the opcode/control interface of the MIPS core.
// Holds the PC, fetches over the imem req/ready handshake, presents the
// registered instruction to the decoder and picks the next PC at retire.
//   clk, rst       : clock, synchronous active-high reset
//   run_i          : fetch enable; 0 parks in S_IDLE after the current retire
//   imem           : instruction-memory master port (req/addr/rdata/ready)
//   instr_o        : registered instruction word
//   opcode_o       : instr_o[31:26]
//   instr_valid_o  : instr_o/opcode_o/pc_o describe a live instruction
//   pc_o           : address of instr_o (also the fetch address)
//   pc_plus4_o     : pc_o + 4, wrapping
//   stall_i        : datapath not accepting; retire when valid & !stall
//   branch_i, zero_i, jump_i : next-PC controls, sampled only at retire
//   retired_o      : one-cycle pulse per retired instruction
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned     PC_WIDTH = PC_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   instr_fetch_unit_if.master    imem,
   output logic [INSTR_W-1:0]    instr_o,
   output logic [OPCODE_W-1:0]   opcode_o,
   output logic                  instr_valid_o,
   output logic [PC_WIDTH-1:0]   pc_o,
   output logic [PC_WIDTH-1:0]   pc_plus4_o,
   input  logic                  stall_i,
   input  logic                  branch_i,
   input  logic                  zero_i,
   input  logic                  jump_i,
   output logic                  retired_o
);

   fetch_state_e         state_q;
   logic [PC_WIDTH-1:0]  pc_q;
   logic [PC_WIDTH-1:0]  pc_plus4_q;
   logic [INSTR_W-1:0]   instr_q;
   logic                 req_q;
   logic                 valid_q;
   logic                 retired_q;

   logic [PC_WIDTH-1:0]  next_pc_d;
   logic [PC_WIDTH-1:0]  next_pc_plus4_d;

   // Low two bits forced to zero so a misaligned parameter cannot leak out.
   localparam logic [PC_WIDTH-1:0] RESET_PC_AL = PC_WIDTH'({RESET_PC[PC_W-1:2], 2'b00});

   pc_next_calc u_pc_next (
      .pc_plus4_i  (pc_plus4_q),
      .instr_idx_i (instr_q[JIDX_W-1:0]),
      .branch_i    (branch_i),
      .zero_i      (zero_i),
      .jump_i      (jump_i),
      .next_pc_c_o (next_pc_d)
   );

   // pc+4 is kept as a register alongside pc so both outputs are flop-driven.
   assign next_pc_plus4_d = next_pc_d + PC_WIDTH'(4);

   // Fetch FSM with registered handshake and decoder outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC_AL;
         pc_plus4_q <= RESET_PC_AL + PC_WIDTH'(4);
         instr_q    <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         retired_q  <= 1'b0;
      end else begin
         retired_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (run_i) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
               end
            end
            S_REQ: begin
               // req_q low here only in the first cycle out of reset.
               if (!req_q) begin
                  if (run_i) begin
                     req_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (imem.ready) begin
                  instr_q <= imem.rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_VALID;
               end
            end
            S_VALID: begin
               if (!stall_i) begin
                  retired_q  <= 1'b1;
                  valid_q    <= 1'b0;
                  pc_q       <= next_pc_d;
                  pc_plus4_q <= next_pc_plus4_d;
                  if (run_i) begin
                     state_q <= S_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.req      = req_q;
   assign imem.addr     = pc_q;
   assign instr_o       = instr_q;
   assign opcode_o      = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];
   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4_q;
   assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump/branch
// next-PC selection, slow memory with stall, reset mid-fetch, PC wrap and
// parking in idle.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        run;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retired;

   instr_fetch_unit_if imem_bus ();

   instr_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .run_i         (run),
      .imem          (imem_bus),
      .instr_o       (instr),
      .opcode_o      (opcode),
      .instr_valid_o (instr_valid),
      .pc_o          (pc),
      .pc_plus4_o    (pc_plus4),
      .stall_i       (stall),
      .branch_i      (branch),
      .zero_i        (zero),
      .jump_i        (jump),
      .retired_o     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Instruction memory model: ready after wait_cycles request cycles;
   // stray forces a ready pulse regardless of req.
   logic [31:0] mem [logic [31:0]];
   int          wait_cycles = 0;
   int          cnt = 0;
   bit          stray = 1'b0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0000_0000;
   endfunction

   always @(posedge clk) begin
      #2;
      if (stray) begin
         imem_bus.ready = 1'b1;
         imem_bus.rdata = 32'hDEAD_BEEF;
         cnt = 0;
      end else if (imem_bus.req) begin
         if (cnt >= wait_cycles) begin
            imem_bus.ready = 1'b1;
            imem_bus.rdata = mem_rd(imem_bus.addr);
         end else begin
            imem_bus.ready = 1'b0;
            imem_bus.rdata = 32'h0000_0000;
            cnt++;
         end
      end else begin
         imem_bus.ready = 1'b0;
         imem_bus.rdata = 32'h0000_0000;
         cnt = 0;
      end
   end

   // Wait for instr_valid (bounded), checking the request is held meanwhile.
   task automatic wait_valid(input logic [31:0] exp_pc, input int exp_lat,
                             input logic [31:0] exp_instr);
      int n;
      n = 0;
      while (instr_valid !== 1'b1 && n < 40) begin
         check("fetch_req_held", 32'(imem_bus.req), 32'd1);
         check("fetch_addr_stable", imem_bus.addr, exp_pc);
         @(negedge clk);
         n++;
      end
      check("fetch_latency", 32'(n), 32'(exp_lat));
      check("pc", pc, exp_pc);
      check("instr", instr, exp_instr);
      check("opcode", 32'(opcode), 32'(exp_instr[31:26]));
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      check("req_low_in_valid", 32'(imem_bus.req), 32'd0);
      check("retired_gap", 32'(retired), 32'd0);
   endtask

   // Drive retire-cycle controls and check the following cycle.
   task automatic retire(input bit br, input bit zr, input bit jp, input bit run_after,
                         input logic [31:0] exp_next);
      branch = br;
      zero   = zr;
      jump   = jp;
      run    = run_after;
      stall  = 1'b0;
      @(negedge clk);
      check("retired_pulse", 32'(retired), 32'd1);
      check("valid_drop", 32'(instr_valid), 32'd0);
      check("next_addr", imem_bus.addr, exp_next);
      check("req_after_retire", 32'(imem_bus.req), 32'(run_after));
      branch = 1'b0;
      zero   = 1'b0;
      jump   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b1; stall = 1'b0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0;

      mem[32'h0000_0000] = 32'h0022_1820;              // add $3,$1,$2
      mem[32'h0000_0004] = 32'h8C22_0008;              // lw  $2,8($1)
      mem[32'h0000_0008] = {OP_J, 26'h000_0004};       // j   0x10
      mem[32'h0000_0010] = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
      mem[32'h0000_000C] = {OP_SW, 5'd1, 5'd2, 16'h0004};
      mem[32'h0000_0014] = {OP_BEQ, 5'd0, 5'd0, 16'hFFF9};
      for (int r = 1; r <= 3; r++) mem[32'(r) << 28] = 32'h0BFF_FFFF;
      mem[32'h4000_0000] = 32'h0800_0010;              // j 0x40 (region 4)
      mem[32'h4000_0040] = 32'h2022_0005;              // addi $2,$1,5

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_bus.req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_pc", pc, 32'h0000_0000);
      check("rst_pc_plus4", pc_plus4, 32'h0000_0004);
      check("rst_instr", instr, 32'h0000_0000);
      rst = 1'b0;
      @(negedge clk);
      check("first_req", 32'(imem_bus.req), 32'd1);
      check("first_addr", imem_bus.addr, 32'h0000_0000);

      // Sequential zero-wait fetch, one retire every two cycles
      wait_valid(32'h0000_0000, 1, 32'h0022_1820);
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
      wait_valid(32'h0000_0004, 1, 32'h8C22_0008);
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
      wait_valid(32'h0000_0008, 1, 32'h0800_0004);
      retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010);

      // beq -2 at 0x10: taken -> 0x0C, not taken -> 0x14
      wait_valid(32'h0000_0010, 1, 32'h1022_FFFE);
      retire(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C);
      wait_valid(32'h0000_000C, 1, 32'hAC22_0004);
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
      wait_valid(32'h0000_0010, 1, 32'h1022_FFFE);
      retire(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014);

      // Backward branch below zero wraps to 0xFFFF_FFFC
      wait_valid(32'h0000_0014, 1, 32'h1000_FFF9);
      retire(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);

      // Non-branch retire at top of memory wraps to 0; run=0 parks in idle
      wait_valid(32'hFFFF_FFFC, 1, 32'h0000_0000);
      retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_req", 32'(imem_bus.req), 32'd0);
         check("idle_valid", 32'(instr_valid), 32'd0);
      end
      mem[32'h0000_0000] = 32'h0BFF_FFFF;
      run = 1'b1;
      @(negedge clk);
      check("idle_exit_req", 32'(imem_bus.req), 32'd1);
      check("idle_exit_addr", imem_bus.addr, 32'h0000_0000);

      // Walk up through the 256 MB regions to reach 0x4000_0000
      wait_valid(32'h0000_0000, 1, 32'h0BFF_FFFF);
      retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0FFF_FFFC);
      for (int r = 1; r <= 3; r++) begin
         wait_valid((32'(r) << 28) - 32'd4, 1, 32'h0000_0000);
         retire(1'b0, 1'b0, 1'b0, 1'b1, 32'(r) << 28);
         wait_valid(32'(r) << 28, 1, 32'h0BFF_FFFF);
         retire(1'b0, 1'b0, 1'b1, 1'b1, (32'(r + 1) << 28) - 32'd4);
      end
      wait_valid(32'h3FFF_FFFC, 1, 32'h0000_0000);
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000);

      // Jump beats a taken branch; next fetch sees a 3-cycle memory delay
      wait_valid(32'h4000_0000, 1, 32'h0800_0010);
      wait_cycles = 3;
      retire(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0040);
      stall = 1'b1;
      wait_valid(32'h4000_0040, 4, 32'h2022_0005);

      // Stall two cycles; controls asserted while stalled must not matter
      branch = 1'b1; zero = 1'b1; jump = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_pc", pc, 32'h4000_0040);
         check("stall_instr", instr, 32'h2022_0005);
         check("stall_retired", 32'(retired), 32'd0);
         check("stall_req", 32'(imem_bus.req), 32'd0);
      end
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0044);
      @(negedge clk);
      check("single_pulse", 32'(retired), 32'd0);
      check("slow_req_held", 32'(imem_bus.req), 32'd1);
      check("slow_addr_held", imem_bus.addr, 32'h4000_0044);

      // Reset while the slow fetch is outstanding; a late ready must be dropped
      rst   = 1'b1;
      stray = 1'b1;
      @(negedge clk);
      check("midrst_req", 32'(imem_bus.req), 32'd0);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_pc", pc, 32'h0000_0000);
      check("midrst_retired", 32'(retired), 32'd0);
      rst         = 1'b0;
      stray       = 1'b0;
      wait_cycles = 0;
      @(negedge clk);
      check("refetch_req", 32'(imem_bus.req), 32'd1);
      check("refetch_addr", imem_bus.addr, 32'h0000_0000);
      check("late_ready_ignored", 32'(instr_valid), 32'd0);
      wait_valid(32'h0000_0000, 1, 32'h0BFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
